// File: rtl/cv_uart_pkg.sv
// cv_uart_pkg: shared types, default rates and sizing helpers for the cv_uart transmitter
package cv_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD = 115_200;
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cv_uart_baud_tick.sv
// cv_baud_tick: restartable 0..BIT_CYC-1 counter flagging the last cycle of each bit
module cv_baud_tick import cv_uart_pkg::*; #(
  parameter int BIT_CYC = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic bit_end
);
  localparam int W = cnt_w(BIT_CYC);
  logic [W-1:0] cnt;
  assign bit_end = cnt == W'(BIT_CYC - 1);
  // Count bit cycles, restarting on clear or after the last cycle of a bit
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else cnt <= clr || bit_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/cv_uart_tx.sv
// cv_uart_tx: 8N1/8N2 UART transmitter; define CV_UART_PARITY_EN to add an even parity bit
module cv_uart_tx import cv_uart_pkg::*; #(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD,
  parameter int STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_RDY_T,
  input  logic [7:0] TX_DATA_T,
  output logic       TX_RDY_R,
  output logic       TXD,
  output logic       BUSY
);
  localparam int BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
  if (BIT_CYC < 2) begin : g_bad_rate
    $error("cv_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("cv_uart_tx: STOP_BITS must be 1 or 2");
  end
  state_t state, state_nxt;
  logic [7:0] shift, shift_nxt;
  logic [2:0] idx, idx_nxt;
  logic txd_nxt, bit_end, last_stop, accept;
`ifdef CV_UART_PARITY_EN
  logic par, par_nxt;
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  cv_baud_tick #(.BIT_CYC(BIT_CYC)) u_tick (
    .CLK(CLK),
    .RST(RST),
    .clr(accept || state == IDLE),
    .bit_end(bit_end)
  );
  // idx is reused to count stop bits; it has wrapped to 0 on leaving DATA
  assign last_stop = state == STOP && bit_end && idx == 3'(STOP_BITS - 1);
  assign accept = TX_RDY_T && (state == IDLE || last_stop);
  assign BUSY = state != IDLE;
  // State register
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nxt;
  // Next-state: a new byte always wins, otherwise advance on bit ends
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = START;
    else if (last_stop) state_nxt = IDLE;
    else if (bit_end)
      case (state)
        START: state_nxt = DATA;
        DATA: state_nxt = idx == 3'd7 ? AFTER_DATA : DATA;
`ifdef CV_UART_PARITY_EN
        PARITY: state_nxt = STOP;
`endif
        default: state_nxt = state;
      endcase
  end
  // Output/datapath next values: line level, shifter, bit index
  always_comb begin
    shift_nxt = shift;
    idx_nxt = idx;
    txd_nxt = TXD;
`ifdef CV_UART_PARITY_EN
    par_nxt = par;
`endif
    if (accept) begin
      shift_nxt = TX_DATA_T;
      idx_nxt = 3'd0;
      txd_nxt = 1'b0;
`ifdef CV_UART_PARITY_EN
      par_nxt = ^TX_DATA_T;
`endif
    end else if (last_stop) begin
      idx_nxt = 3'd0;
      txd_nxt = 1'b1;
    end else if (bit_end)
      case (state)
        START: txd_nxt = shift[0];
        DATA: begin
          shift_nxt = shift >> 1;
          idx_nxt = idx + 3'd1;
`ifdef CV_UART_PARITY_EN
          txd_nxt = idx == 3'd7 ? par : shift[1];
`else
          txd_nxt = idx == 3'd7 ? 1'b1 : shift[1];
`endif
        end
`ifdef CV_UART_PARITY_EN
        PARITY: txd_nxt = 1'b1;
`endif
        STOP: idx_nxt = idx + 3'd1;
        default: txd_nxt = TXD;
      endcase
  end
  // Datapath registers; TXD is registered so the pin never glitches
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      shift <= '0;
      idx <= '0;
      TXD <= 1'b1;
      TX_RDY_R <= 1'b0;
`ifdef CV_UART_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      shift <= shift_nxt;
      idx <= idx_nxt;
      TXD <= txd_nxt;
      TX_RDY_R <= accept;
`ifdef CV_UART_PARITY_EN
      par <= par_nxt;
`endif
    end
endmodule

// File: tb/tb_cv_uart_tx.sv
// tb_cv_uart_tx: self-checking bench for cv_uart_tx at BIT_CYC=4
module tb_cv_uart_tx;
  localparam int BC = 4;
  localparam int SB = 1;
`ifdef CV_UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 9 + PB + SB;
  localparam int FL = NB * BC;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic TX_RDY_T = 1'b0;
  logic [7:0] TX_DATA_T = 8'h00;
  logic TX_RDY_R, TXD, BUSY;
  int vecs = 0;
  int errs = 0;
  typedef struct {
    logic [7:0] data;
    logic       hold;
    logic [7:0] exp_byte;
    logic       exp_par;
  } vec_t;
  vec_t tbl[9];
  cv_uart_tx #(.CLK_FREQ(400), .BAUD(100), .STOP_BITS(SB)) dut (
    .CLK(CLK),
    .RST(RST),
    .TX_RDY_T(TX_RDY_T),
    .TX_DATA_T(TX_DATA_T),
    .TX_RDY_R(TX_RDY_R),
    .TXD(TXD),
    .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic idle(input string n, input int c);
    int bad = 0;
    repeat (c) begin
      @(negedge CLK);
      if ({TXD, TX_RDY_R, BUSY} !== 3'b100) bad++;
    end
    chk(n, bad, 0);
  endtask
  // Line level expected during bit b of a frame carrying d
  function automatic logic ebit(input logic [7:0] d, input logic p, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PB == 1 && b == 9) return p;
    return 1'b1;
  endfunction
  // Wait up to mw cycles for the accept pulse, then check one whole frame.
  // At sample fk the upstream inputs switch to (nv, nd).
  task automatic frame(input logic [7:0] d, input logic p, input int mw,
                       input logic nv, input logic [7:0] nd, input int fk);
    int w = 0;
    int rbad = 0;
    int bbad = 0;
    logic got = 1'b0;
    logic s[FL];
    logic [7:0] dec;
    logic [31:0] v, e;
    while (!got && w < mw) begin
      @(negedge CLK);
      w++;
      got = TX_RDY_R;
    end
    chk($sformatf("accept %02h within %0d", d, mw), got, 1);
    if (!got) return;
    for (int k = 0; k < FL; k++) begin
      if (k > 0) @(negedge CLK);
      if (k == fk) begin
        TX_RDY_T = nv;
        TX_DATA_T = nd;
      end
      s[k] = TXD;
      if (TX_RDY_R !== (k == 0)) rbad++;
      if (BUSY !== 1'b1) bbad++;
    end
    for (int b = 0; b < NB; b++) begin
      v = '0;
      e = '0;
      for (int j = 0; j < BC; j++) begin
        v[j] = s[b*BC+j];
        e[j] = ebit(d, p, b);
      end
      chk($sformatf("txd bit%0d of %02h", b, d), v, e);
    end
    for (int i = 0; i < 8; i++) dec[i] = s[(i+1)*BC+BC/2];
    chk("decoded byte", dec, d);
    chk($sformatf("extra rdy cycles in %02h", d), rbad, 0);
    chk($sformatf("busy low cycles in %02h", d), bbad, 0);
  endtask
  initial begin
    int mw;
    logic h, got;
    logic [7:0] rd[17];
    tbl[0] = '{8'h41, 1'b0, 8'h41, 1'b0};
    tbl[1] = '{8'h43, 1'b0, 8'h43, 1'b1};
    tbl[2] = '{8'h4F, 1'b1, 8'h4F, 1'b1};
    tbl[3] = '{8'h4B, 1'b1, 8'h4B, 1'b0};
    tbl[4] = '{8'h0D, 1'b1, 8'h0D, 1'b1};
    tbl[5] = '{8'h0A, 1'b0, 8'h0A, 1'b0};
    tbl[6] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[7] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[8] = '{8'h80, 1'b0, 8'h80, 1'b1};
    repeat (2) @(negedge CLK);
    chk("reset state", {TXD, TX_RDY_R, BUSY}, 3'b100);
    RST = 1'b0;
    idle("idle 100 cycles", 100);
    TX_DATA_T = tbl[0].data;
    TX_RDY_T = 1'b1;
    mw = 4;
    for (int i = 0; i < 9; i++) begin
      frame(tbl[i].exp_byte, tbl[i].exp_par, mw, tbl[i].hold, i < 8 ? tbl[i+1].data : 8'h00, 0);
      if (!tbl[i].hold) begin
        idle("table gap", 3);
        TX_RDY_T = i < 8;
      end
      mw = tbl[i].hold ? 1 : 4;
    end
    TX_DATA_T = 8'h55;
    TX_RDY_T = 1'b1;
    frame(8'h55, 1'b0, 4, 1'b1, 8'hAA, 4 * BC);
    frame(8'hAA, 1'b0, 1, 1'b0, 8'h00, 0);
    idle("after flip", 5);
    TX_DATA_T = 8'h77;
    TX_RDY_T = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 4 && !got; w++) begin
      @(negedge CLK);
      got = TX_RDY_R;
    end
    chk("accept 77 before reset", got, 1);
    TX_DATA_T = 8'h31;
    repeat (4 * BC) @(negedge CLK);
    chk("txd at data bit3 of 77", TXD, 0);
    RST = 1'b1;
    #1;
    chk("async reset mid-frame", {TXD, TX_RDY_R, BUSY}, 3'b100);
    repeat (2) @(negedge CLK);
    chk("held in reset", {TXD, TX_RDY_R, BUSY}, 3'b100);
    RST = 1'b0;
    frame(8'h31, 1'b1, 3, 1'b0, 8'h00, 0);
    idle("after reset frame", 5);
    for (int i = 0; i < 17; i++) rd[i] = 8'($urandom);
    TX_DATA_T = rd[0];
    TX_RDY_T = 1'b1;
    mw = 4;
    for (int i = 0; i < 16; i++) begin
      h = i == 15 ? 1'b0 : 1'($urandom_range(0, 1));
      frame(rd[i], ^rd[i], mw, h, rd[i+1], 0);
      if (!h) begin
        idle("random gap", int'($urandom_range(1, 5)));
        TX_RDY_T = i < 15;
      end
      mw = h ? 1 : 4;
    end
    idle("final idle", 10);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
